freq_to_code: RTL and testbench



---
 rtl/filt_map_pkg.sv | 30 +++
 rtl/cubic_map.sv | 17 +
 rtl/freq_to_code.sv | 117 +++++++++++
 tb/tb_freq_to_code.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/filt_map_pkg.sv
// Shared definitions for the cubic code <-> cutoff mapping.
// map_freq/map_cube are the single source of f(c) for both conversion directions.
package filt_map_pkg;

    localparam int unsigned MDefault    = 10;
    localparam int unsigned NDefault    = 15;
    localparam int unsigned FmaxDefault = 20000;
    localparam int unsigned FminDefault = 20;
    localparam int unsigned IntW        = 64;

    typedef enum logic [1:0] {StIdle, StCube, StCmp, StDone} state_e;

    // f from a precomputed c^3; the divide by 2^(3M) is a plain shift of the full product
    function automatic logic [IntW-1:0] map_cube(input logic [IntW-1:0] cube,
                                                 input int unsigned     m,
                                                 input int unsigned     fmax,
                                                 input int unsigned     fmin);
        logic [IntW-1:0] prod;
        prod = IntW'(fmax - fmin) * cube;
        return (prod >> (3 * m)) + IntW'(fmin);
    endfunction

    function automatic logic [IntW-1:0] map_freq(input logic [IntW-1:0] c,
                                                 input int unsigned     m,
                                                 input int unsigned     fmax,
                                                 input int unsigned     fmin);
        return map_cube(c * c * c, m, fmax, fmin);
    endfunction

endpackage

// File: rtl/cubic_map.sv
// Combinational code-to-cutoff evaluator working from the cube of the code.
module cubic_map
    import filt_map_pkg::*;
#(
    parameter int unsigned M    = MDefault,
    parameter int unsigned N    = NDefault,
    parameter int unsigned FMAX = FmaxDefault,
    parameter int unsigned FMIN = FminDefault
) (
    input  logic [3*M-1:0] cube,
    output logic [N-1:0]   freq
);

    // f never exceeds FMAX, so the narrowing to N bits is lossless for sane parameters
    assign freq = N'(map_cube(IntW'(cube), M, FMAX, FMIN));

endmodule

// File: rtl/freq_to_code.sv
// Cutoff-to-code converter: successive-approximation search over the cubic map,
// one code bit per CUBE/CMP pair, valid/ready handshakes on both sides.
module freq_to_code
    import filt_map_pkg::*;
#(
    parameter int unsigned M    = MDefault,
    parameter int unsigned N    = NDefault,
    parameter int unsigned FMAX = FmaxDefault,
    parameter int unsigned FMIN = FminDefault
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] freq_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] code_out,
    output logic         under_out
);

    localparam int unsigned IdxW = (M > 1) ? $clog2(M) : 1;
    localparam logic [N-1:0] FminN = N'(FMIN);

    state_e          state_q, state_d;
    logic [N-1:0]    freq_q, freq_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [M-1:0]    result_q, result_d;
    logic [3*M-1:0]  cube_q, cube_d;
    logic            under_q, under_d;

    logic [M-1:0]    trial;
    logic [3*M-1:0]  trial_w;
    logic [N-1:0]    trial_freq;

    // result_q and idx_q are untouched between CUBE and CMP, so trial is rebuilt rather than stored
    assign trial   = result_q | (M'(1) << idx_q);
    assign trial_w = (3 * M)'(trial);

    cubic_map #(
        .M    (M),
        .N    (N),
        .FMAX (FMAX),
        .FMIN (FMIN)
    ) u_cubic_map (
        .cube (cube_q),
        .freq (trial_freq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            freq_q   <= '0;
            idx_q    <= '0;
            result_q <= '0;
            cube_q   <= '0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cube_q   <= cube_d;
            under_q  <= under_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        freq_d    = freq_q;
        idx_d     = idx_q;
        result_d  = result_q;
        cube_d    = cube_q;
        under_d   = under_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    freq_d   = freq_in;
                    idx_d    = IdxW'(M - 1);
                    result_d = '0;
                    under_d  = 1'b0;
                    state_d  = StCube;
                end
            end
            StCube: begin
                cube_d  = trial_w * trial_w * trial_w;
                state_d = StCmp;
            end
            StCmp: begin
                if (trial_freq <= freq_q) begin
                    result_d = trial;
                end
                if (idx_q == '0) begin
                    under_d = (freq_q < FminN);
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = StCube;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign code_out  = result_q;
    assign under_out = under_q;

endmodule

// File: tb/tb_freq_to_code.sv
// Self-checking bench for freq_to_code against a table-driven model of the cubic map.
module tb_freq_to_code;

    localparam int unsigned M = 10;
    localparam int unsigned N = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] freq_in;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] code_out;
    logic         under_out;

    logic [3*M-1:0] cm_cube;
    logic [N-1:0]   cm_freq;

    int n_assert = 0;
    int n_fail   = 0;

    longint unsigned fvals [1024];

    freq_to_code #(
        .M    (M),
        .N    (N),
        .FMAX (20000),
        .FMIN (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .freq_in   (freq_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .under_out (under_out)
    );

    cubic_map #(
        .M    (M),
        .N    (N),
        .FMAX (20000),
        .FMIN (20)
    ) u_ref_map (
        .cube (cm_cube),
        .freq (cm_freq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic longint unsigned ref_f(input int c);
        longint unsigned cc;
        cc = longint'(c);
        return ((64'd19980 * cc * cc * cc) >> 30) + 64'd20;
    endfunction

    // Largest code whose mapped frequency fits under the target; 0 if none does
    function automatic int ref_code(input longint unsigned f);
        for (int c = 1023; c >= 0; c--) begin
            if (fvals[c] <= f) return c;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [N-1:0] f, output logic [M-1:0] code,
                          output logic under, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        freq_in  = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        code  = code_out;
        under = under_out;
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [N-1:0] f,
                             input int exp_code, input bit exp_under);
        logic [M-1:0] code;
        logic         under;
        int           lat;
        do_req(f, code, under, lat);
        check({tag, "_latency"}, 64'(lat), 64'd20);
        check({tag, "_code"}, 64'(code), 64'(exp_code));
        check({tag, "_under"}, 64'(under), 64'(exp_under));
        release_out();
    endtask

    initial begin
        logic [M-1:0] code;
        logic         under;
        logic [M-1:0] held;
        int           lat;
        int           seen;
        logic [N-1:0] f;

        for (int c = 0; c < 1024; c++) fvals[c] = ref_f(c);

        reset     = 1'b1;
        in_valid  = 1'b0;
        freq_in   = '0;
        out_ready = 1'b0;
        cm_cube   = '0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_code", 64'(code_out), 64'd0);
        check("rst_under", 64'(under_out), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed boundary points
        run_check("f2517", 15'd2517, 512, 1'b0);
        run_check("f2516", 15'd2516, 511, 1'b0);
        run_check("f20", 15'd20, 37, 1'b0);
        run_check("f19", 15'd19, 0, 1'b1);
        run_check("f0", 15'd0, 0, 1'b1);
        run_check("f19941", 15'd19941, 1023, 1'b0);
        run_check("f19940", 15'd19940, 1022, 1'b0);
        run_check("f20000", 15'd20000, 1023, 1'b0);
        run_check("f32767", 15'd32767, 1023, 1'b0);

        // Random targets against the model
        for (int i = 0; i < 40; i++) begin
            f = N'($urandom_range(0, 32767));
            if (i < 10) f = N'($urandom_range(0, 40));
            run_check("rand", f, ref_code(64'(f)), (f < 15'd20));
        end

        // Backpressure: hold DONE, poke in_valid, result must not move
        do_req(15'd5000, held, under, lat);
        check("bp_code", 64'(held), 64'(ref_code(64'd5000)));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            freq_in  = 15'd100;
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_code_stable", 64'(code_out), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_accept_cycle", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_out_valid_after", 64'(out_valid), 64'd0);
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        run_check("bp_next", 15'd2517, 512, 1'b0);

        // Reset while comparing bit 5
        @(negedge clk);
        in_valid = 1'b1;
        freq_in  = 15'd3000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_code", 64'(code_out), 64'd0);
        check("midrst_under", 64'(under_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        check("midrst_no_stale_valid", 64'(seen), 64'd0);
        run_check("midrst_next", 15'd3000, ref_code(64'd3000), 1'b0);

        // Round trip over every code through the shared evaluator
        for (int c = 0; c < 1024; c++) begin
            cm_cube = 30'(longint'(c) * longint'(c) * longint'(c));
            #1;
            check("map_eval", 64'(cm_freq), fvals[c]);
            do_req(cm_freq, code, under, lat);
            check("rt_latency", 64'(lat), 64'd20);
            check("rt_code", 64'(code), 64'(ref_code(fvals[c])));
            check("rt_map_back", fvals[code], fvals[c]);
            release_out();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
